// File: rtl/exposure_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exposure_timer_ctrl
// Description : Exposure down-counter with prescaler, pause/resume, abort,
//               one-shot / auto-reload modes, a done pulse and a saturating
//               count of completed exposure periods.
// Revision    : 1.0 - initial release
// ============================================================================
module exposure_timer_ctrl #(
    parameter int WIDTH = 5,
    parameter int PS_W  = 4,
    parameter int PER_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_set,
    input  logic             ex_start,
    input  logic             ex_abort,
    input  logic             ex_reload,
    input  logic [WIDTH-1:0] ex_init,
    input  logic [PS_W-1:0]  ex_prescale,
    output logic             ex_done,
    output logic             ex_done_pulse,
    output logic             ex_busy,
    output logic [WIDTH-1:0] ex_count,
    output logic [PER_W-1:0] ex_periods
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_PAUSED = 2'd3;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] init_lat;
    logic [PS_W-1:0]  presc;
    logic [PS_W-1:0]  ps_lat;
    logic             reload_lat;
    logic [PER_W-1:0] periods;
    logic             done_pulse;
    logic             busy;
    logic             busy_nxt;
    logic             en_edge;
    logic             tick;
    logic             period_end;

    // Decode enabled edges, prescaler ticks and period completion
    always_comb begin
        en_edge    = ex_start && (state != S_IDLE);
        tick       = en_edge && (presc == ps_lat);
        period_end = tick && (count == CNT_ONE);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort beats set, set beats counting
    always_comb begin
        state_nxt = state;
        if (ex_abort) begin
            state_nxt = S_IDLE;
        end else if (ex_set) begin
            state_nxt = (ex_init == '0) ? S_IDLE : S_ARMED;
        end else begin
            case (state)
                S_ARMED, S_PAUSED: begin
                    if (ex_start) begin
                        state_nxt = (period_end && !reload_lat) ? S_IDLE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!ex_start) begin
                        state_nxt = S_PAUSED;
                    end else if (period_end && !reload_lat) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: level done from the count, busy from the next state
    always_comb begin
        ex_done  = (count == '0);
        busy_nxt = (state_nxt != S_IDLE);
    end

    // Registered status outputs; the pulse only fires when counting reaches zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            done_pulse <= !ex_abort && !ex_set && period_end;
        end
    end

    // Count, prescaler, latched configuration and period counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            presc      <= '0;
            periods    <= '0;
            init_lat   <= '0;
            ps_lat     <= '0;
            reload_lat <= 1'b0;
        end else if (ex_abort) begin
            count <= '0;
            presc <= '0;
        end else if (ex_set) begin
            init_lat   <= ex_init;
            ps_lat     <= ex_prescale;
            reload_lat <= ex_reload;
            count      <= ex_init;
            presc      <= '0;
            periods    <= '0;
        end else if (en_edge) begin
            if (tick) begin
                presc <= '0;
                if (period_end) begin
                    count <= reload_lat ? init_lat : '0;
                    if (periods != PER_MAX) begin
                        periods <= periods + 1'b1;
                    end
                end else if (count != '0) begin
                    count <= count - 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign ex_done_pulse = done_pulse;
    assign ex_busy       = busy;
    assign ex_count      = count;
    assign ex_periods    = periods;

endmodule
`default_nettype wire

// File: tb/tb_exposure_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exposure_timer_ctrl
// Description : Directed and randomized stimulus for exposure_timer_ctrl,
//               checked against a model that tracks enabled edges since arming
//               and derives count/pulse/periods arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exposure_timer_ctrl;

    localparam int WIDTH   = 5;
    localparam int PS_W    = 4;
    localparam int PER_W   = 4;
    localparam int PER_MAX = (1 << PER_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ex_set, ex_start, ex_abort, ex_reload;
    logic [WIDTH-1:0] ex_init;
    logic [PS_W-1:0]  ex_prescale;
    logic             ex_done, ex_done_pulse, ex_busy;
    logic [WIDTH-1:0] ex_count;
    logic [PER_W-1:0] ex_periods;

    int checks   = 0;
    int failures = 0;

    // Reference model: exposure described by enabled edges since arming
    bit m_active;
    int m_e;
    int m_n;
    int m_p;
    bit m_r;
    int m_per_held;
    bit m_pulse;

    exposure_timer_ctrl #(.WIDTH(WIDTH), .PS_W(PS_W), .PER_W(PER_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_set        (ex_set),
        .ex_start      (ex_start),
        .ex_abort      (ex_abort),
        .ex_reload     (ex_reload),
        .ex_init       (ex_init),
        .ex_prescale   (ex_prescale),
        .ex_done       (ex_done),
        .ex_done_pulse (ex_done_pulse),
        .ex_busy       (ex_busy),
        .ex_count      (ex_count),
        .ex_periods    (ex_periods)
    );

    always #5 clk = ~clk;

    function automatic int period_len();
        return m_n * (m_p + 1);
    endfunction

    function automatic int exp_count();
        if (!m_active) return 0;
        return m_n - (m_e % period_len()) / (m_p + 1);
    endfunction

    function automatic int exp_periods();
        int q;
        if (!m_active) return m_per_held;
        q = m_e / period_len();
        return (q > PER_MAX) ? PER_MAX : q;
    endfunction

    task automatic model_reset();
        m_active   = 1'b0;
        m_e        = 0;
        m_n        = 0;
        m_p        = 0;
        m_r        = 1'b0;
        m_per_held = 0;
        m_pulse    = 1'b0;
    endtask

    task automatic model_edge(bit ab, bit st, bit go, bit rl, int ini, int ps);
        m_pulse = 1'b0;
        if (ab) begin
            if (m_active) m_per_held = exp_periods();
            m_active = 1'b0;
        end else if (st) begin
            m_n        = ini;
            m_p        = ps;
            m_r        = rl;
            m_e        = 0;
            m_per_held = 0;
            m_active   = (ini != 0);
        end else if (m_active && go) begin
            m_e = m_e + 1;
            if (m_e % period_len() == 0) m_pulse = 1'b1;
            if (!m_r && m_e == period_len()) begin
                m_active   = 1'b0;
                m_per_held = 1;
            end
        end
    endtask

    task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, expv);
        end
    endtask

    task automatic check_all(string tag);
        int c;
        c = exp_count();
        chk(tag, "count",   32'(ex_count),      32'(c));
        chk(tag, "done",    32'(ex_done),       32'(c == 0));
        chk(tag, "pulse",   32'(ex_done_pulse), 32'(m_pulse));
        chk(tag, "busy",    32'(ex_busy),       32'(m_active));
        chk(tag, "periods", 32'(ex_periods),    32'(exp_periods()));
    endtask

    task automatic step(string tag, bit ab, bit st, bit go, bit rl, int ini, int ps);
        logic [31:0] iv;
        logic [31:0] pv;
        iv          = 32'(ini);
        pv          = 32'(ps);
        ex_abort    = ab;
        ex_set      = st;
        ex_start    = go;
        ex_reload   = rl;
        ex_init     = iv[WIDTH-1:0];
        ex_prescale = pv[PS_W-1:0];
        @(posedge clk);
        model_edge(ab, st, go, rl, ini, ps);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n     = 1'b0;
        ex_set      = 1'b0;
        ex_start    = 1'b0;
        ex_abort    = 1'b0;
        ex_reload   = 1'b0;
        ex_init     = '0;
        ex_prescale = '0;
        model_reset();
        #2;
        check_all("reset");
        #10 reset_n = 1'b1;

        // One-shot, init 3, prescale 0, start held through set
        step("os_set", 0, 1, 1, 0, 3, 0);
        chk("os_set", "count_const", 32'(ex_count), 32'd3);
        for (int i = 0; i < 3; i++) step("os_run", 0, 0, 1, 0, 9, 5);
        chk("os_end", "pulse_const", 32'(ex_done_pulse), 32'd1);
        chk("os_end", "busy_const",  32'(ex_busy),       32'd0);
        step("os_after", 0, 0, 1, 0, 0, 0);

        // Pause: init 2, prescale 2, pause 4 cycles after 2nd enabled edge
        step("ps_set", 0, 1, 0, 0, 2, 2);
        for (int i = 0; i < 2; i++) step("ps_run1", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ps_hold", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ps_run2", 0, 0, 1, 0, 0, 0);
        chk("ps_end", "pulse_const", 32'(ex_done_pulse), 32'd1);

        // Auto-reload init 4, long enough to saturate the period counter
        step("rl_set", 0, 1, 0, 1, 4, 0);
        for (int i = 0; i < 70; i++) step("rl_run", 0, 0, 1, 0, 1, 3);
        chk("rl_sat", "periods_const", 32'(ex_periods), 32'd15);

        // Set with init 0, then abort together with set
        step("zero_set", 0, 1, 1, 1, 0, 0);
        step("zero_idle", 0, 0, 1, 0, 0, 0);
        step("ab_arm", 0, 1, 0, 0, 6, 1);
        step("ab_set", 1, 1, 1, 0, 9, 0);
        chk("ab_set", "count_const", 32'(ex_count), 32'd0);

        // Re-set during RUN at count 2
        step("rs_set", 0, 1, 1, 0, 5, 0);
        for (int i = 0; i < 3; i++) step("rs_run", 0, 0, 1, 0, 0, 0);
        step("rs_reset7", 0, 1, 1, 0, 7, 0);
        chk("rs_reset7", "count_const", 32'(ex_count), 32'd7);
        step("rs_run7", 0, 0, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit ab, st, go, rl;
            int ini, ps;
            ab  = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 15) == 0);
            go  = ($urandom_range(0, 3) != 0);
            rl  = $urandom_range(0, 1);
            ini = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            ps  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            step("rand", ab, st, go, rl, ini, ps);
        end

        // Asynchronous reset in the middle of a run
        step("ar_set", 0, 1, 1, 1, 9, 1);
        for (int i = 0; i < 5; i++) step("ar_run", 0, 0, 1, 0, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all("ar_assert");
        #14 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step("ar_after", 0, 0, 1, 1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
